// File: rtl/fir_transposed_param.sv
// Parametrised transposed-form FIR filter with a double-buffered coefficient bank,
// valid-qualified streaming, synchronous flush, and round-half-up output scaling with saturation.
module fir_transposed_param #(
    parameter int TAPS      = 33,
    parameter int DATA_W    = 3,
    parameter int COEF_W    = 16,
    parameter int ACC_W     = 25,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic                       iClk_12M,
    input  logic                       iRst,
    input  logic                       iInValid,
    input  logic signed [DATA_W-1:0]   iFirIn,
    input  logic                       iFlush,
    input  logic                       iCoeffWe,
    input  logic [$clog2(TAPS)-1:0]    iCoeffAddr,
    input  logic signed [COEF_W-1:0]   iCoeffData,
    input  logic                       iCoeffCommit,
    output logic                       oCoeffBusy,
    output logic                       oOutValid,
    output logic signed [OUT_W-1:0]    oFirOut,
    output logic                       oSat
);

    localparam int ADDR_W = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic [ADDR_W:0]       TAPS_L  = (ADDR_W+1)'(TAPS);
    localparam logic [ACC_W:0]        RND_U   = ({{ACC_W{1'b0}}, 1'b1} << OUT_SHIFT) >> 1;
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } coef_state_t;

    // Widened by one bit so the rounding constant can never wrap the sum.
    function automatic logic signed [ACC_W:0] f_round(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] w_ext;
        w_ext = {acc[ACC_W-1], acc};
        return (w_ext + $signed(RND_U)) >>> OUT_SHIFT;
    endfunction

    // Returns {saturated, clamped value}.
    function automatic logic [OUT_W:0] f_sat(input logic signed [ACC_W:0] r);
        if (r > SAT_MAX) begin
            return {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (r < SAT_MIN) begin
            return {1'b1, SAT_MIN[OUT_W-1:0]};
        end
        return {1'b0, r[OUT_W-1:0]};
    endfunction

    logic signed [COEF_W-1:0] r_shadow [TAPS];
    logic signed [COEF_W-1:0] r_active [TAPS];
    logic signed [ACC_W-1:0]  r_dly    [TAPS-1];
    logic signed [ACC_W-1:0]  w_prod   [TAPS];

    coef_state_t r_state;
    coef_state_t w_state_nxt;
    logic        w_shadow_we;
    logic        w_copy;

    logic signed [PROD_W-1:0] w_x_ext;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W:0]    w_round;
    logic [OUT_W:0]           w_satv;

    logic                     r_out_vld;
    logic signed [OUT_W-1:0]  r_out;
    logic                     r_sat;

    // ---- stage 0: one product per tap, all from the same input sample ----
    assign w_x_ext = {{COEF_W{iFirIn[DATA_W-1]}}, iFirIn};

    for (genvar k = 0; k < TAPS; k++) begin : g_prod
        logic signed [PROD_W-1:0] w_h_ext;
        logic signed [PROD_W-1:0] w_mul;
        assign w_h_ext   = {{DATA_W{r_active[k][COEF_W-1]}}, r_active[k]};
        assign w_mul     = w_x_ext * w_h_ext;
        assign w_prod[k] = {{(ACC_W-PROD_W){w_mul[PROD_W-1]}}, w_mul};
    end

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < TAPS-1; i++) begin
                r_dly[i] <= '0;
            end
        end else if (iFlush) begin
            for (int i = 0; i < TAPS-1; i++) begin
                r_dly[i] <= '0;
            end
        end else if (iInValid) begin
            r_dly[0] <= w_prod[TAPS-1];
            for (int j = 1; j < TAPS-1; j++) begin
                r_dly[j] <= r_dly[j-1] + w_prod[TAPS-1-j];
            end
        end
    end

    assign w_acc   = r_dly[TAPS-2] + w_prod[0];
    assign w_round = f_round(w_acc);
    assign w_satv  = f_sat(w_round);

    // ---- stage 1: registered output; a flushed sample produces no output ----
    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            r_out_vld <= 1'b0;
            r_out     <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_out_vld <= iInValid & ~iFlush;
            if (iInValid && !iFlush) begin
                r_out <= w_satv[OUT_W-1:0];
                r_sat <= w_satv[OUT_W];
            end
        end
    end

    assign oOutValid = r_out_vld;
    assign oFirOut   = r_out;
    assign oSat      = r_sat;

    // Commit waits for an idle input cycle so no sample ever sees a mixed coefficient set.
    always_comb begin
        w_state_nxt = r_state;
        w_shadow_we = 1'b0;
        w_copy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_shadow_we = iCoeffWe && ({1'b0, iCoeffAddr} < TAPS_L);
                if (iCoeffCommit) begin
                    w_state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (!iInValid) begin
                    w_copy      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign oCoeffBusy = (r_state == ST_PENDING);

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_shadow_we) begin
            r_shadow[iCoeffAddr] <= iCoeffData;
        end
    end

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_active[i] <= '0;
            end
        end else if (w_copy) begin
            for (int i = 0; i < TAPS; i++) begin
                r_active[i] <= r_shadow[i];
            end
        end
    end

endmodule

// File: tb/tb_fir_transposed_param.sv
// Directed bench for fir_transposed_param: one instance unscaled, one with OUT_SHIFT=2,
// both driven from the same stimulus.
module tb_fir_transposed_param;

    localparam int TAPS = 33;

    typedef struct {
        logic flush;
        int   x;
        int   exp_out;
        logic exp_sat;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [2:0]  fir_in = '0;
    logic               flush = 1'b0;
    logic               coef_we = 1'b0;
    logic [5:0]         coef_addr = '0;
    logic signed [15:0] coef_data = '0;
    logic               commit = 1'b0;

    logic               busy_a, vld_a, sat_a;
    logic signed [15:0] out_a;
    logic               busy_b, vld_b, sat_b;
    logic signed [15:0] out_b;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vq[$];

    fir_transposed_param #(.TAPS(TAPS), .DATA_W(3), .COEF_W(16), .ACC_W(25), .OUT_W(16), .OUT_SHIFT(0)) u_dut_a (
        .iClk_12M(clk), .iRst(rst), .iInValid(in_valid), .iFirIn(fir_in), .iFlush(flush),
        .iCoeffWe(coef_we), .iCoeffAddr(coef_addr), .iCoeffData(coef_data), .iCoeffCommit(commit),
        .oCoeffBusy(busy_a), .oOutValid(vld_a), .oFirOut(out_a), .oSat(sat_a)
    );

    fir_transposed_param #(.TAPS(TAPS), .DATA_W(3), .COEF_W(16), .ACC_W(25), .OUT_W(16), .OUT_SHIFT(2)) u_dut_b (
        .iClk_12M(clk), .iRst(rst), .iInValid(in_valid), .iFirIn(fir_in), .iFlush(flush),
        .iCoeffWe(coef_we), .iCoeffAddr(coef_addr), .iCoeffData(coef_data), .iCoeffCommit(commit),
        .oCoeffBusy(busy_b), .oOutValid(vld_b), .oFirOut(out_b), .oSat(sat_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input int k, input int v);
        coef_we   = 1'b1;
        coef_addr = 6'(k);
        coef_data = 16'(v);
        step();
        coef_we   = 1'b0;
    endtask

    task automatic commit_idle(input string tag);
        in_valid = 1'b0;
        commit   = 1'b1;
        step();
        commit   = 1'b0;
        chk({tag, " busy set"}, int'(busy_a), 1);
        step();
        chk({tag, " busy clear"}, int'(busy_a), 0);
    endtask

    task automatic add_vec(input logic f, input int x, input int e, input logic s);
        vec_t v;
        v.flush = f; v.x = x; v.exp_out = e; v.exp_sat = s;
        vq.push_back(v);
    endtask

    task automatic run_vecs(input string tag);
        foreach (vq[i]) begin
            if (vq[i].flush) begin
                in_valid = 1'b0;
                flush    = 1'b1;
                step();
                flush    = 1'b0;
            end
            in_valid = 1'b1;
            fir_in   = 3'(vq[i].x);
            step();
            chk($sformatf("%s[%0d] vld", tag, i), int'(vld_a), 1);
            chk($sformatf("%s[%0d] out", tag, i), int'(out_a), vq[i].exp_out);
            chk($sformatf("%s[%0d] sat", tag, i), int'(sat_a), int'(vq[i].exp_sat));
        end
        in_valid = 1'b0;
        fir_in   = '0;
        vq.delete();
    endtask

    initial begin
        // Asynchronous reset: outputs must be zero before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("reset out", int'(out_a), 0);
        chk("reset vld", int'(vld_a), 0);
        chk("reset sat", int'(sat_a), 0);
        chk("reset busy", int'(busy_a), 0);
        chk("reset out_b", int'(out_b), 0);
        #20 rst = 1'b0;

        // Coefficients are zero after reset.
        in_valid = 1'b1; fir_in = 3'sd1;
        step();
        chk("zero-coef vld", int'(vld_a), 1);
        chk("zero-coef out", int'(out_a), 0);
        in_valid = 1'b0; fir_in = '0;
        step();
        chk("idle vld", int'(vld_a), 0);

        // Impulse response with h[k] = k+1.
        for (int k = 0; k < TAPS; k++) wr(k, k + 1);
        commit_idle("impulse commit");
        add_vec(1'b0, 1, 1, 1'b0);
        for (int n = 1; n <= 40; n++) add_vec(1'b0, 0, (n < TAPS) ? n + 1 : 0, 1'b0);
        run_vecs("impulse");

        // Flush in the middle of an impulse response.
        in_valid = 1'b1; fir_in = 3'sd1;
        step();
        fir_in = '0;
        for (int n = 2; n <= 10; n++) begin
            step();
            chk($sformatf("flush pre out %0d", n), int'(out_a), n);
        end
        in_valid = 1'b0;
        step();
        chk("hold vld", int'(vld_a), 0);
        chk("hold out", int'(out_a), 10);
        flush = 1'b1; in_valid = 1'b1; fir_in = 3'sd1;
        step();
        flush = 1'b0; fir_in = '0;
        chk("flush vld", int'(vld_a), 0);
        chk("flush out hold", int'(out_a), 10);
        for (int n = 0; n < 5; n++) begin
            step();
            chk($sformatf("post flush vld %0d", n), int'(vld_a), 1);
            chk($sformatf("post flush out %0d", n), int'(out_a), 0);
        end

        // Commit deferral while streaming continuously.
        coef_we = 1'b1; coef_addr = 6'd0; coef_data = 16'sd100;
        step();
        coef_we = 1'b0;
        chk("defer a out", int'(out_a), 0);
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk("defer b busy", int'(busy_a), 1);
        fir_in = 3'sd1; coef_we = 1'b1; coef_addr = 6'd1; coef_data = 16'sd55;
        step();
        coef_we = 1'b0; fir_in = '0;
        chk("defer c out", int'(out_a), 1);
        chk("defer c busy", int'(busy_a), 1);
        step();
        chk("defer d out", int'(out_a), 2);
        chk("defer d busy", int'(busy_a), 1);
        step();
        chk("defer e out", int'(out_a), 3);
        in_valid = 1'b0;
        step();
        chk("defer f busy", int'(busy_a), 0);
        chk("defer f vld", int'(vld_a), 0);
        chk("defer f out", int'(out_a), 3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b1; fir_in = 3'sd1;
        step();
        chk("new set h0", int'(out_a), 100);
        fir_in = '0;
        step();
        chk("new set h1", int'(out_a), 2);
        in_valid = 1'b0;
        step();

        // Rounding on the OUT_SHIFT=2 instance, h[0]=6 only.
        for (int k = 0; k < TAPS; k++) wr(k, (k == 0) ? 6 : 0);
        commit_idle("round commit");
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b1;
        fir_in = 3'sd1;  step(); chk("round x=1 b", int'(out_b), 2);  chk("round x=1 a", int'(out_a), 6);
        fir_in = -3'sd1; step(); chk("round x=-1 b", int'(out_b), -1); chk("round x=-1 a", int'(out_a), -6);
        fir_in = 3'sd3;  step(); chk("round x=3 b", int'(out_b), 5);
        fir_in = -3'sd3; step(); chk("round x=-3 b", int'(out_b), -4);
        fir_in = '0;     step(); chk("round x=0 b", int'(out_b), 0);
        in_valid = 1'b0;

        // Saturation with all taps at full scale.
        for (int k = 0; k < TAPS; k++) wr(k, 32767);
        commit_idle("sat commit");
        add_vec(1'b1, -4, -32768, 1'b1);
        add_vec(1'b0, 0, -32768, 1'b1);
        add_vec(1'b1, 3, 32767, 1'b1);
        for (int n = 1; n < TAPS; n++) add_vec(1'b0, 0, 32767, 1'b1);
        add_vec(1'b0, 0, 0, 1'b0);
        run_vecs("sat");

        // Asynchronous reset mid-stream with a commit pending.
        in_valid = 1'b1; fir_in = -3'sd4; commit = 1'b1;
        step();
        commit = 1'b0; fir_in = '0;
        chk("pre-rst out", int'(out_a), -32768);
        chk("pre-rst sat", int'(sat_a), 1);
        chk("pre-rst busy", int'(busy_a), 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst out", int'(out_a), 0);
        chk("async rst vld", int'(vld_a), 0);
        chk("async rst sat", int'(sat_a), 0);
        chk("async rst busy", int'(busy_a), 0);
        @(posedge clk);
        #3 rst = 1'b0;
        step();
        chk("post-rst vld", int'(vld_a), 1);
        chk("post-rst dly", int'(out_a), 0);
        fir_in = 3'sd3;
        step();
        chk("post-rst active", int'(out_a), 0);
        chk("post-rst sat", int'(sat_a), 0);
        fir_in = '0;
        commit_idle("post-rst commit");
        in_valid = 1'b1; fir_in = 3'sd3;
        step();
        chk("post-rst shadow", int'(out_a), 0);
        in_valid = 1'b0; fir_in = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fir_transposed_param.md
Name: fir_transposed_param

Overview:
Parametrised transposed-form FIR filter. It is the successor of the fixed 33-tap, hard-wired-coefficient transposed filter. Tap count, data width, coefficient width and output scaling are all parameters. Coefficients load at run time into a shadow bank and move to the active bank atomically. The block also adds valid-qualified streaming, synchronous flush, and rounding with saturation on the output. It sits between the sample source and the downstream output stage, in the same slot as the fixed transposed filter.

Parameters:
TAPS, 33, number of filter taps (>=2)
DATA_W, 3, signed input sample width
COEF_W, 16, signed coefficient width
ACC_W, 25, signed accumulator / delay-register width (>= DATA_W+COEF_W+clog2(TAPS))
OUT_W, 16, signed output width
OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before saturation (0..ACC_W-1)

Ports:
iClk_12M  in  1  clock, rising edge
iRst  in  1  asynchronous active-high reset
iInValid  in  1  input sample valid; state advances only when high
iFirIn  in  DATA_W  signed input sample
iFlush  in  1  synchronous clear of the delay line
iCoeffWe  in  1  shadow coefficient write strobe
iCoeffAddr  in  clog2(TAPS)  tap index k of h[k]
iCoeffData  in  COEF_W  signed coefficient value
iCoeffCommit  in  1  pulse; requests the shadow-to-active copy
oCoeffBusy  out  1  commit pending
oOutValid  out  1  output sample valid
oFirOut  out  OUT_W  signed filtered output
oSat  out  1  oFirOut was saturated (qualified by oOutValid)

Behaviour:
- Reset (iRst=1, async): all delay registers, active and shadow banks, oFirOut, oOutValid, oSat and the pending flag go to 0. Outputs read 0 immediately, with no clock required. Reset may assert mid-stream; the sample in flight is lost.
- Filter function: y[n] = sum over k=0..TAPS-1 of h[k]*x[n-k], using active-bank coefficients. Samples count only on iInValid cycles.
- Transposed structure, TAPS-1 delay registers d[0..TAPS-2], ACC_W wide, all sign-extended. On an iInValid edge:
  - d[0] <= x*h[TAPS-1]
  - d[j] <= d[j-1] + x*h[TAPS-1-j]
  - acc = d[TAPS-2] + x*h[0]
- Latency: oOutValid pulses 1 cycle after the accepted sample, once per accepted sample. With iInValid low, the delay line holds, oOutValid=0, and oFirOut/oSat hold their last values.
- Scaling:
  - OUT_SHIFT=0: r = acc.
  - OUT_SHIFT>0: r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, i.e. round half up.
- Saturation: if r > 2^(OUT_W-1)-1 or r < -2^(OUT_W-1), oFirOut clamps to that limit and oSat=1. Otherwise oFirOut = r and oSat=0.
- Intermediate sums are not saturated; ACC_W must be sized to prevent wrap.
- Coefficient load FSM, states IDLE and PENDING:
  - IDLE: iCoeffWe=1 writes iCoeffData to shadow[iCoeffAddr]. An address >= TAPS is ignored. iCoeffCommit=1 moves to PENDING, and oCoeffBusy=1 from the next cycle.
  - PENDING: iCoeffWe and iCoeffCommit are ignored. On the first edge with iInValid=0, the whole shadow bank is copied to the active bank and the FSM returns to IDLE.
  - While iInValid stays high, the copy is deferred, so every sample uses one consistent coefficient set.
  - The shadow bank keeps its contents after the copy.
- iCoeffWe and iCoeffCommit in the same IDLE cycle: the write lands, then PENDING is entered. The copy includes that write.
- iFlush=1: on the edge, all d[] <= 0 and oOutValid <= 0. It takes priority over iInValid in the same cycle; that sample is dropped. oFirOut/oSat hold. Coefficient banks and the FSM are unaffected.
- The first TAPS-1 outputs after reset or flush reflect zero history.

Test Plan:
- Impulse: load h[k]=k+1 (TAPS=33) and commit. Feed x=1 followed by 40 zeros, all valid. Expected: oFirOut = 1,2,...,33, then 0, with oSat=0 and one oOutValid per sample.
- Saturation: all h=32767, OUT_SHIFT=0, single x=-4. Expected: r=-131068, oFirOut=-32768, oSat=1. A following x=0 gives the next output -131068 again (tap 1), still saturated.
- Rounding: OUT_SHIFT=2, h[0]=6, other taps 0. x=1 gives oFirOut=2. x=-1 gives oFirOut=-1.
- Commit deferral: with the impulse coefficients active, stream continuous valid, write h[0]=100 and commit mid-stream. Expected: oCoeffBusy stays 1 and outputs keep the old set. Then drop iInValid for one cycle; busy clears, and the next x=1 gives first output 100.
- Flush: mid-impulse-response (output 10 just seen), assert iFlush with iInValid=1. Expected: no oOutValid next cycle, and the subsequent zero inputs give 0.
- Async reset: assert iRst between clock edges mid-stream. Expected: oFirOut, oOutValid and oSat are 0 immediately; after release, zero inputs give 0 because the coefficients are cleared.
